// File: rtl/normshift_pipe.sv
// rtl/normshift_pipe.sv - 3-stage valid/ready normalization shifter for the FPU rounder
// Optional feature macro: NORMSHIFT_STICKY_EN (defined: STICKY from discarded bits; undefined: STICKY = 0)
module normshift_pipe #(
  parameter int FW = 57,
  parameter int EW = 13,
  parameter int OW = 128,
  parameter int XW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [FW-1:0] fr,
  input  logic [EW-1:0] er,
  input  logic          db,
  input  logic          OVFen,
  input  logic          UNFen,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] fn,
  output logic [XW-1:0] eni,
  output logic [XW-1:0] en,
  output logic          TINY,
  output logic          OVF1,
  output logic          STICKY
);
  localparam int LZW = $clog2(FW + 1);
  localparam int SW  = EW + 1;

  localparam logic signed [SW-1:0] ONE     = SW'(1);
  localparam logic signed [SW-1:0] EMIN_D  = SW'(-1022);
  localparam logic signed [SW-1:0] EMIN_S  = SW'(-126);
  localparam logic signed [SW-1:0] EMAX_D  = SW'(1023);
  localparam logic signed [SW-1:0] EMAX_S  = SW'(127);
  localparam logic signed [SW-1:0] ALPHA_D = SW'(1536);
  localparam logic signed [SW-1:0] ALPHA_S = SW'(192);
  localparam logic [SW-1:0]        OW_X    = SW'(OW);

  // pipeline occupancy and advance conditions
  logic v1, v2, v3;
  logic adv2, adv3;

  assign adv3      = !v3 || out_ready;
  assign adv2      = !v2 || adv3;
  assign in_ready  = !v1 || adv2;
  assign out_valid = v3;

  // stage 1 registers
  logic [FW-1:0]  fr1;
  logic [EW-1:0]  er1;
  logic           db1, ovfen1, unfen1;
  logic [LZW-1:0] lz1, lz_c;

  // stage 2 registers
  logic [FW-1:0]        fr2;
  logic signed [SW-1:0] sh2;

  // leading-zero count of the incoming significand; FW when it is zero
  always_comb begin
    lz_c = LZW'(FW);
    for (int i = 0; i < FW; i++) begin
      if (fr[i]) lz_c = LZW'(FW - 1 - i);
    end
  end

  // stage 1: capture operands and leading-zero count
  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      fr1    <= '0;
      er1    <= '0;
      db1    <= 1'b0;
      ovfen1 <= 1'b0;
      unfen1 <= 1'b0;
      lz1    <= '0;
    end else if (in_ready) begin
      v1 <= in_valid;
      if (in_valid) begin
        fr1    <= fr;
        er1    <= er;
        db1    <= db;
        ovfen1 <= OVFen;
        unfen1 <= UNFen;
        lz1    <= lz_c;
      end
    end
  end

  // stage 2 combinational: exponent, range flags and signed shift amount
  logic signed [SW-1:0] er_x, lz_x, e_p, emin_x, emax_x, bias_x, alpha_x, adj, ew_c, sh_c;
  logic                 nz, tiny_c, ovf_c, denorm;
  logic [XW-1:0]        eni_c, en_c;

  // denormal results keep the exponent pinned at emin, so the shift absorbs the deficit
  always_comb begin
    er_x    = {er1[EW-1], er1};
    lz_x    = {{(SW-LZW){1'b0}}, lz1};
    emin_x  = db1 ? EMIN_D : EMIN_S;
    emax_x  = db1 ? EMAX_D : EMAX_S;
    bias_x  = db1 ? EMAX_D : EMAX_S;
    alpha_x = db1 ? ALPHA_D : ALPHA_S;
    nz      = |fr1;
    e_p     = er_x + ONE - lz_x;
    tiny_c  = nz && (e_p < emin_x);
    ovf_c   = nz && (e_p > emax_x);
    denorm  = tiny_c && !unfen1;
    sh_c    = denorm ? (er_x - emin_x) : (lz_x - ONE);
    adj     = '0;
    if (ovf_c && ovfen1)      adj = -alpha_x;
    else if (tiny_c && unfen1) adj = alpha_x;
    ew_c    = e_p + bias_x + adj;
    eni_c   = ew_c[XW-1:0];
    en_c    = (!nz || denorm) ? '0 : eni_c;
  end

  logic [XW-1:0] eni2, en2;
  logic          tiny2, ovf2;

  // stage 2: register exponent results and shift amount
  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      fr2   <= '0;
      sh2   <= '0;
      eni2  <= '0;
      en2   <= '0;
      tiny2 <= 1'b0;
      ovf2  <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        fr2   <= fr1;
        sh2   <= sh_c;
        eni2  <= eni_c;
        en2   <= en_c;
        tiny2 <= tiny_c;
        ovf2  <= ovf_c;
      end
    end
  end

  // stage 3 combinational: bidirectional shift of the widened significand
  logic [OW-1:0] ext, fn_c;
  logic [SW-1:0] rsh;

  always_comb begin
    ext = {fr2, {(OW-FW){1'b0}}};
    rsh = -sh2;
    if (!sh2[SW-1])     fn_c = ext << sh2;
    else if (rsh >= OW_X) fn_c = '0;
    else                fn_c = ext >> rsh;
  end

`ifdef NORMSHIFT_STICKY_EN
  logic sticky_c;

  // OR of every bit that falls below bit 0 on a right shift
  always_comb begin
    if (!sh2[SW-1])       sticky_c = 1'b0;
    else if (rsh >= OW_X) sticky_c = |ext;
    else                  sticky_c = |(ext & ~({OW{1'b1}} << rsh));
  end
`else
  assign STICKY = 1'b0;
`endif

  // stage 3: output registers, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      v3   <= 1'b0;
      fn   <= '0;
      eni  <= '0;
      en   <= '0;
      TINY <= 1'b0;
      OVF1 <= 1'b0;
`ifdef NORMSHIFT_STICKY_EN
      STICKY <= 1'b0;
`endif
    end else if (adv3) begin
      v3 <= v2;
      if (v2) begin
        fn   <= fn_c;
        eni  <= eni2;
        en   <= en2;
        TINY <= tiny2;
        OVF1 <= ovf2;
`ifdef NORMSHIFT_STICKY_EN
        STICKY <= sticky_c;
`endif
      end
    end
  end

endmodule
